// File: rtl/branch_resolve_arbiter_pkg.sv
// Shared types and configuration for the branch resolve arbiter slice.
//   SqN        : wrapping sequence number used for age ordering
//   BranchProv : redirect provided by an ALU port (taken = valid mispredict)
//   BTUpdate   : BTB training update (valid qualifies)
//   isOlder / isYounger : wrap-safe age compares over the SqN width
package branch_resolve_arbiter_pkg;

    localparam int unsigned SQN_W           = 7;
    localparam int unsigned PC_W            = 16;
    localparam int unsigned NUM_BR_PORTS    = 2;
    localparam int unsigned BTU_QUEUE_DEPTH = 4;

    typedef logic [SQN_W-1:0] SqN;

    typedef struct packed {
        logic            taken;
        SqN              sqN;
        logic [PC_W-1:0] dst;
        logic [PC_W-1:0] src;
    } BranchProv;

    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] src;
        logic [PC_W-1:0] dst;
        logic            isCall;
        logic            isRet;
    } BTUpdate;

    // a older than b iff signed(a - b) < 0, i.e. the MSB of the wrapped difference
    function automatic logic isOlder(input SqN a, input SqN b);
        SqN diff;
        diff = a - b;
        return diff[SQN_W-1];
    endfunction

    // a younger than b iff signed(a - b) > 0
    function automatic logic isYounger(input SqN a, input SqN b);
        SqN diff;
        diff = a - b;
        return !diff[SQN_W-1] && (diff != '0);
    endfunction

endpackage

// File: rtl/branch_resolve_arbiter_if.sv
// Bundle of branch/update signals between the ALU ports, the arbiter and fetch/BTB.
//   master : drives IN_* (ALU side and BTB ready), observes OUT_*
//   slave  : the arbiter; consumes IN_*, drives OUT_*
interface branch_resolve_arbiter_if
    import branch_resolve_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS = NUM_BR_PORTS
);

    BranchProv  IN_branch   [NUM_PORTS];
    BTUpdate    IN_btUpdate [NUM_PORTS];
    logic       IN_btReady;
    BranchProv  OUT_branch;
    BTUpdate    OUT_btUpdate;
    logic [7:0] OUT_btDrops;

    modport master (
        output IN_branch,
        output IN_btUpdate,
        output IN_btReady,
        input  OUT_branch,
        input  OUT_btUpdate,
        input  OUT_btDrops
    );

    modport slave (
        input  IN_branch,
        input  IN_btUpdate,
        input  IN_btReady,
        output OUT_branch,
        output OUT_btUpdate,
        output OUT_btDrops
    );

endinterface

// File: rtl/branch_resolve_arbiter_bt_update_queue.sv
// bt_update_queue: multi-enqueue / single-dequeue circular buffer for BTB updates.
//   clk, rst   : clock, asynchronous active-high reset
//   IN_update  : per-port updates, enqueued in ascending port order when valid
//   IN_ready   : consumer takes the head this cycle
//   OUT_head   : show-ahead head entry, valid = queue non-empty
//   OUT_drops  : saturating count of updates dropped for lack of space
module bt_update_queue
    import branch_resolve_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS = NUM_BR_PORTS,
    parameter int unsigned DEPTH     = BTU_QUEUE_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  BTUpdate    IN_update [NUM_PORTS],
    input  logic       IN_ready,
    output BTUpdate    OUT_head,
    output logic [7:0] OUT_drops
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    BTUpdate mem [DEPTH];

    logic [PtrW-1:0] rdQ, rdD, wrQ, wrD;
    logic [CntW-1:0] countQ, countD;
    logic [7:0]      dropsQ, dropsD;

    logic            deq;
    logic [CntW-1:0] free;
    logic [CntW-1:0] accepted;
    logic [7:0]      dropped;
    logic [8:0]      dropSum;
    logic            wrEn  [NUM_PORTS];
    logic [PtrW-1:0] wrIdx [NUM_PORTS];

    always_comb begin
        deq      = IN_ready && (countQ != '0);
        // a slot vacated by this cycle's dequeue can be refilled immediately
        free     = CntW'(DEPTH) - countQ + CntW'(deq);
        accepted = '0;
        dropped  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            wrEn[p]  = 1'b0;
            wrIdx[p] = wrQ + accepted[PtrW-1:0];
            if (IN_update[p].valid) begin
                if (accepted < free) begin
                    wrEn[p]  = 1'b1;
                    accepted = accepted + CntW'(1);
                end else begin
                    dropped = dropped + 8'd1;
                end
            end
        end
        // pointers wrap naturally at DEPTH since DEPTH is a power of two
        rdD     = rdQ + PtrW'(deq);
        wrD     = wrQ + accepted[PtrW-1:0];
        countD  = countQ - CntW'(deq) + accepted;
        dropSum = {1'b0, dropsQ} + {1'b0, dropped};
        dropsD  = dropSum[8] ? 8'hFF : dropSum[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdQ    <= '0;
            wrQ    <= '0;
            countQ <= '0;
            dropsQ <= '0;
        end else begin
            rdQ    <= rdD;
            wrQ    <= wrD;
            countQ <= countD;
            dropsQ <= dropsD;
        end
    end

    // storage needs no reset: entries are only exposed while count says they are live
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (wrEn[p]) begin
                mem[wrIdx[p]] <= IN_update[p];
            end
        end
    end

    always_comb begin
        OUT_head = '0;
        if (countQ != '0) begin
            OUT_head       = mem[rdQ];
            OUT_head.valid = 1'b1;
        end
        OUT_drops = dropsQ;
    end

endmodule

// File: rtl/branch_resolve_arbiter.sv
// branch_resolve_arbiter: picks the oldest non-squashed mispredict among the ALU
// ports and registers it as the single frontend redirect; funnels BTB training
// updates into one queued stream.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of branch_resolve_arbiter_if
//              IN_branch/IN_btUpdate per port, IN_btReady from BTB,
//              OUT_branch (registered), OUT_btUpdate (queue head), OUT_btDrops
module branch_resolve_arbiter
    import branch_resolve_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS = NUM_BR_PORTS,
    parameter int unsigned BTU_DEPTH = BTU_QUEUE_DEPTH
) (
    input logic                     clk,
    input logic                     rst,
    branch_resolve_arbiter_if.slave bus
);

    BranchProv  branchQ, branchD;
    BranchProv  winner;
    logic       found;
    logic       candidate [NUM_PORTS];
    BTUpdate    updates   [NUM_PORTS];
    BTUpdate    head;
    logic [7:0] drops;

    // A port is squashed when it is younger than the redirect issued last cycle.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            candidate[p] = bus.IN_branch[p].taken &&
                           !(branchQ.taken && isYounger(bus.IN_branch[p].sqN, branchQ.sqN));
        end
    end

    // Ascending scan with strict older-than keeps the lowest port on equal sqN.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (candidate[p] && (!found || isOlder(bus.IN_branch[p].sqN, winner.sqN))) begin
                winner = bus.IN_branch[p];
                found  = 1'b1;
            end
        end
        branchD       = winner;
        branchD.taken = found;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branchQ <= '0;
        end else begin
            branchQ <= branchD;
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            updates[p] = bus.IN_btUpdate[p];
        end
    end

    bt_update_queue #(
        .NUM_PORTS (NUM_PORTS),
        .DEPTH     (BTU_DEPTH)
    ) u_btQueue (
        .clk       (clk),
        .rst       (rst),
        .IN_update (updates),
        .IN_ready  (bus.IN_btReady),
        .OUT_head  (head),
        .OUT_drops (drops)
    );

    assign bus.OUT_branch   = branchQ;
    assign bus.OUT_btUpdate = head;
    assign bus.OUT_btDrops  = drops;

endmodule

// File: tb/tb_branch_resolve_arbiter.sv
// Directed + randomized bench for branch_resolve_arbiter with a scoreboard for
// redirects and a reference queue for BTB updates.
module tb_branch_resolve_arbiter;
    import branch_resolve_arbiter_pkg::*;

    localparam int unsigned NP    = 2;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_resolve_arbiter_if #(.NUM_PORTS(NP)) bus ();

    branch_resolve_arbiter #(
        .NUM_PORTS (NP),
        .BTU_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int        total = 0;
    int        bad   = 0;
    BranchProv expBrQ [$];
    BTUpdate   modelQ [$];
    int        modelDrops = 0;
    BranchProv modelOut   = '0;
    logic [15:0] updSeq   = 16'h0100;
    BTUpdate   firstUpd;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic driveBr(input logic t0, input SqN s0, input logic t1, input SqN s1);
        bus.IN_branch[0] = '{taken: t0, sqN: s0, dst: 16'hA000 | 16'(s0), src: 16'h1000 | 16'(s0)};
        bus.IN_branch[1] = '{taken: t1, sqN: s1, dst: 16'hB000 | 16'(s1), src: 16'h2000 | 16'(s1)};
    endtask

    task automatic driveUpd(input logic v0, input logic v1, input logic ready);
        logic v [NP];
        v[0] = v0;
        v[1] = v1;
        for (int p = 0; p < NP; p++) begin
            bus.IN_btUpdate[p] = '{valid: v[p], src: updSeq, dst: updSeq ^ 16'h5A5A,
                                   isCall: updSeq[0], isRet: updSeq[1]};
            updSeq = updSeq + 16'd1;
        end
        bus.IN_btReady = ready;
    endtask

    // Compute expectations from the currently driven inputs, clock once, compare.
    task automatic cycle(input string tag);
        BranchProv best;
        BranchProv ib;
        BranchProv exp;
        logic      fnd;
        logic      cand;
        best = '0;
        fnd  = 1'b0;
        for (int p = 0; p < NP; p++) begin
            ib   = bus.IN_branch[p];
            cand = ib.taken && !(modelOut.taken && ($signed(SqN'(ib.sqN - modelOut.sqN)) > 0));
            if (cand && (!fnd || ($signed(SqN'(ib.sqN - best.sqN)) < 0))) begin
                best = ib;
                fnd  = 1'b1;
            end
        end
        best.taken = fnd;
        expBrQ.push_back(best);
        modelOut = best;

        if (bus.IN_btReady && modelQ.size() > 0) void'(modelQ.pop_front());
        for (int p = 0; p < NP; p++) begin
            if (bus.IN_btUpdate[p].valid) begin
                if (modelQ.size() < DEPTH) modelQ.push_back(bus.IN_btUpdate[p]);
                else if (modelDrops < 255) modelDrops++;
            end
        end

        @(posedge clk);
        #1;
        exp = expBrQ.pop_front();
        check({tag, ".taken"}, 64'(bus.OUT_branch.taken), 64'(exp.taken));
        if (exp.taken) begin
            check({tag, ".sqN"}, 64'(bus.OUT_branch.sqN), 64'(exp.sqN));
            check({tag, ".dst"}, 64'(bus.OUT_branch.dst), 64'(exp.dst));
        end
        check({tag, ".btValid"}, 64'(bus.OUT_btUpdate.valid), 64'(modelQ.size() != 0));
        if (modelQ.size() != 0) begin
            check({tag, ".btHead"}, 64'(bus.OUT_btUpdate), 64'(modelQ[0]));
        end
        check({tag, ".drops"}, 64'(bus.OUT_btDrops), 64'(modelDrops));
    endtask

    task automatic idle(input string tag, input logic ready);
        driveBr(1'b0, '0, 1'b0, '0);
        driveUpd(1'b0, 1'b0, ready);
        cycle(tag);
    endtask

    initial begin
        rst = 1'b1;
        driveBr(1'b0, '0, 1'b0, '0);
        driveUpd(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst.taken", 64'(bus.OUT_branch.taken), 64'd0);
        check("rst.btValid", 64'(bus.OUT_btUpdate.valid), 64'd0);
        check("rst.drops", 64'(bus.OUT_btDrops), 64'd0);
        rst = 1'b0;

        // oldest wins across ports
        driveBr(1'b1, 7'd10, 1'b1, 7'd7);
        cycle("prio");
        check("prio.sqN7", 64'(bus.OUT_branch.sqN), 64'd7);
        idle("prio.after", 1'b0);
        check("prio.oneCycle", 64'(bus.OUT_branch.taken), 64'd0);

        // younger than last redirect is squashed
        driveBr(1'b1, 7'd20, 1'b0, '0);
        cycle("sq.first");
        driveBr(1'b0, '0, 1'b1, 7'd25);
        cycle("sq.younger");
        check("sq.squashed", 64'(bus.OUT_branch.taken), 64'd0);
        driveBr(1'b1, 7'd20, 1'b0, '0);
        cycle("sq.again");
        driveBr(1'b0, '0, 1'b1, 7'd15);
        cycle("sq.older");
        check("sq.older15", 64'(bus.OUT_branch.sqN), 64'd15);
        driveBr(1'b1, 7'd15, 1'b1, 7'd15);
        cycle("sq.equal");
        check("sq.equalPort0", 64'(bus.OUT_branch.dst), 64'hA00F);
        idle("sq.idle", 1'b0);

        // wrap-safe compare
        driveBr(1'b1, 7'h7E, 1'b1, 7'h01);
        cycle("wrap");
        check("wrap.sqN", 64'(bus.OUT_branch.sqN), 64'h7E);
        idle("wrap.idle", 1'b0);

        // fill the queue with no consumer: 6 offered, 4 kept, 2 dropped
        driveBr(1'b0, '0, 1'b0, '0);
        driveUpd(1'b1, 1'b1, 1'b0);
        firstUpd = bus.IN_btUpdate[0];
        cycle("fill0");
        check("fill0.noBypass", 64'(bus.OUT_btUpdate), 64'(firstUpd));
        driveUpd(1'b1, 1'b1, 1'b0);
        cycle("fill1");
        driveUpd(1'b1, 1'b1, 1'b0);
        cycle("fill2");
        check("fill.drops2", 64'(bus.OUT_btDrops), 64'd2);
        check("fill.head", 64'(bus.OUT_btUpdate), 64'(firstUpd));

        // full + ready + both valid: one in, one dropped
        driveUpd(1'b1, 1'b1, 1'b1);
        cycle("full.deq");
        check("full.drops3", 64'(bus.OUT_btDrops), 64'd3);

        for (int i = 0; i < 6; i++) idle("drain", 1'b1);

        // randomized mix
        for (int i = 0; i < 60; i++) begin
            driveBr(1'($urandom_range(0, 1)), SqN'($urandom_range(0, 127)),
                    1'($urandom_range(0, 1)), SqN'($urandom_range(0, 127)));
            driveUpd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
            cycle("rand");
        end

        // async reset with 3 queued entries and a live redirect
        for (int i = 0; i < 6; i++) idle("drain2", 1'b1);
        driveBr(1'b0, '0, 1'b0, '0);
        driveUpd(1'b1, 1'b1, 1'b0);
        cycle("pre.a");
        driveBr(1'b1, 7'd40, 1'b0, '0);
        driveUpd(1'b1, 1'b0, 1'b0);
        cycle("pre.b");
        driveBr(1'b0, '0, 1'b0, '0);
        driveUpd(1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst.taken", 64'(bus.OUT_branch.taken), 64'd0);
        check("arst.btValid", 64'(bus.OUT_btUpdate.valid), 64'd0);
        check("arst.drops", 64'(bus.OUT_btDrops), 64'd0);
        modelOut   = '0;
        modelDrops = 0;
        modelQ.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle("post.rst", 1'b1);
        driveBr(1'b1, 7'd90, 1'b0, '0);
        driveUpd(1'b1, 1'b0, 1'b0);
        cycle("post.run");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve_arbiter.md
# branch_resolve_arbiter

Collects branch-resolution outputs from all integer ALU ports and arbitrates them to the single frontend redirect. It also funnels branch-target training updates into one queued stream for the BTB. It sits between the IntALU ports and the fetch/BTB logic. Per cycle it forwards the oldest mispredict, squashes redirects younger than the one just issued, and buffers BTB updates behind a ready handshake.

## Interface
Parameters:
- NUM_PORTS, 2, number of ALU ports feeding branches/updates
- BTU_DEPTH, 4, BTB-update queue entries (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- IN_branch  in  NUM_PORTS×BranchProv  per-port redirect; `taken` = valid mispredict
- IN_btUpdate  in  NUM_PORTS×BTUpdate  per-port BTB training update; `valid` qualifies
- IN_btReady  in  1  BTB accepts head update this cycle
- OUT_branch  out  BranchProv  registered winning redirect; `taken` qualifies
- OUT_btUpdate  out  BTUpdate  queue head (show-ahead); `valid` = queue non-empty
- OUT_btDrops  out  8  saturating count of updates dropped on overflow

## Operation
- Age compare: A older than B iff $signed(A.sqN − B.sqN) < 0 (wrap-safe over SqN width).
- Candidate port p: IN_branch[p].taken and not squashed.
  - Squashed when OUT_branch.taken is currently 1 and $signed(IN_branch[p].sqN − OUT_branch.sqN) > 0.
- Winner: oldest candidate. Equal sqN resolves to the lowest port index.
- Next OUT_branch: winner's full struct with taken=1. With no candidate, taken=0 and the other fields are don't-care.
- BTB queue: circular buffer, rd/wr pointers log2(BTU_DEPTH) bits plus count of log2(BTU_DEPTH)+1 bits.
  - deq = IN_btReady && count≠0.
  - free = BTU_DEPTH − count + deq. A slot freed by a same-cycle dequeue is reusable.
  - Valid IN_btUpdate entries enqueue in ascending port order, up to free.
  - Excess entries are dropped. OUT_btDrops += dropped count, saturating at 255.
  - Updates are never flushed by redirects. They are training hints only.
- OUT_btUpdate: struct at rd pointer, valid = (count≠0). Head is stable until dequeued.

## Timing
- Reset (async assert, all state): OUT_branch.taken=0, count=0, rd=wr=0, OUT_btUpdate.valid=0, OUT_btDrops=0. Release takes effect at the next clk edge.
- Redirect latency: 1 cycle, from IN_branch to registered OUT_branch. OUT_branch.taken lasts exactly 1 cycle per winner.
- Back-to-back redirects are allowed when the newer one is strictly older (or equal sqN) than the previous output.
- Queue: enqueued entry visible on OUT_btUpdate the next cycle at earliest. No same-cycle bypass.
- Full + IN_btReady + NUM_PORTS valid inputs: exactly 1 accepted, NUM_PORTS−1 dropped.
- Empty + IN_btReady: no dequeue, pointers unchanged.
- Pointer wrap: modulo BTU_DEPTH, so no special-casing is needed.
- Reset mid-operation discards queued entries and any pending redirect.

## Structure
- BranchProv, BTUpdate, SqN come from the shared package. No new typedefs.
- Add a BTU_QUEUE_DEPTH constant to the shared config package as the default for BTU_DEPTH.
- Sub-module bt_update_queue: multi-enqueue / single-dequeue circular buffer with drop counter.
- Age selection is an inline combinational reduction in the top module.

## Test plan
- Port0 taken sqN=10 and port1 taken sqN=7, same cycle → next cycle OUT_branch.taken=1, sqN=7. The following cycle taken=0.
- Cycle n: port0 taken sqN=20 → OUT_branch sqN=20 in n+1. Cycle n+1: port1 taken sqN=25 → squashed, OUT_branch.taken=0 in n+2. Port1 sqN=15 instead → emitted in n+2.
- Wrap: port0 sqN=0x7E, port1 sqN=0x01 (7-bit SqN) → winner 0x7E.
- IN_btReady=0, 2 valid updates/cycle for 3 cycles (DEPTH=4) → count=4, OUT_btDrops=2. Head equals the first port0 update.
- Full queue, IN_btReady=1, both ports valid → head advances, port0 update accepted, port1 dropped, count stays 4, drops+1.
- Async rst pulse mid-cycle with queue 3 deep and OUT_branch.taken=1 → outputs clear immediately. OUT_btDrops=0.
